// File: rtl/data_mem_responder_pkg.sv
// +----------------------------------------------------------------------+
// | data_mem_responder_pkg                                               |
// | Shared types and default parameters for the multi-cycle data memory. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package data_mem_responder_pkg;

  localparam int          WORD_W            = 32;
  localparam int          DEFAULT_DEPTH     = 64;
  localparam int          DEFAULT_ADDR_W    = 6;
  localparam int          DEFAULT_LATENCY   = 4;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/data_mem_responder_addr_map.sv
// +----------------------------------------------------------------------+
// | dmem_addr_map                                                        |
// | Byte address to word index, plus out-of-range flag when the          |
// | DMEM_BOUNDS_CHECK_EN macro is defined (otherwise the index wraps).   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module dmem_addr_map
  import data_mem_responder_pkg::*;
#(
  parameter int                DEPTH     = DEFAULT_DEPTH,
  parameter int                ADDR_W    = DEFAULT_ADDR_W,
  parameter logic [WORD_W-1:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic [WORD_W-1:0] addr_i,
  output logic [ADDR_W-1:0] idx_o,
  output logic              oor_o
);

  logic [WORD_W-1:0] w_offset;
  logic              w_unused_bits;

  assign w_offset      = addr_i - BASE_ADDR;
  assign idx_o         = w_offset[ADDR_W+1:2];
  // Byte lane and bits above the array span do not select a word.
  assign w_unused_bits = ^{w_offset[WORD_W-1:ADDR_W+2], w_offset[1:0]};

`ifdef DMEM_BOUNDS_CHECK_EN
  localparam logic [WORD_W-1:0] c_end_addr = BASE_ADDR + WORD_W'(4 * DEPTH);
  assign oor_o = (addr_i < BASE_ADDR) || (addr_i >= c_end_addr);
`else
  assign oor_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// +----------------------------------------------------------------------+
// | data_mem_responder                                                   |
// | Multi-cycle load/store data memory with a one-cycle ready pulse.     |
// | Optional range check: DMEM_BOUNDS_CHECK_EN.  Rev 1.0                 |
// +----------------------------------------------------------------------+
`default_nettype none

module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int                DEPTH     = DEFAULT_DEPTH,
  parameter int                ADDR_W    = DEFAULT_ADDR_W,
  parameter int                LATENCY   = DEFAULT_LATENCY,
  parameter logic [WORD_W-1:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  localparam logic [3:0] c_lat_m1 = 4'(LATENCY - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] addr_q, wdata_q, rdata_q;
  logic              wr_q, rd_q, err_q;
  logic [WORD_W-1:0] mem_q [DEPTH];

  logic              w_idle, w_accept, w_enter_done;
  logic              w_cur_wr, w_cur_rd, w_oor;
  logic [WORD_W-1:0] w_cur_addr, w_cur_wdata;
  logic [ADDR_W-1:0] w_idx;

  assign w_idle       = (state_q == IDLE);
  assign w_accept     = w_idle && (mem_read || mem_write);
  assign w_enter_done = (state_d == DONE) && (state_q != DONE);

  // With LATENCY==1 the commit edge is the accept edge, so use the live inputs.
  assign w_cur_addr  = w_idle ? addr      : addr_q;
  assign w_cur_wdata = w_idle ? wdata     : wdata_q;
  assign w_cur_wr    = w_idle ? mem_write : wr_q;
  assign w_cur_rd    = w_idle ? mem_read  : rd_q;

  dmem_addr_map #(
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_addr_map (
    .addr_i (w_cur_addr),
    .idx_o  (w_idx),
    .oor_o  (w_oor)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          cnt_d   = c_lat_m1;
          state_d = (LATENCY == 1) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q == BUSY);
    ready = (state_q == DONE);
    err   = err_q;
    rdata = rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        wr_q    <= mem_write;
        rd_q    <= mem_read;
      end
      err_q <= w_enter_done && w_oor;
      // A combined read+write is a write; rdata is left untouched.
      if (w_enter_done) begin
        if (w_cur_wr) begin
          if (!w_oor) begin
            mem_q[w_idx] <= w_cur_wdata;
          end
        end else if (w_cur_rd) begin
          rdata_q <= w_oor ? '0 : mem_q[w_idx];
        end
      end
    end
  end

endmodule

`default_nettype wire
